// File: rtl/bno085_pkg.sv
// Shared constants and types for the BNO085 SHTP report parser.
package bno085_pkg;

    localparam int unsigned SHTP_HDR_LEN = 4;
    localparam logic [7:0]  TIMEBASE_ID  = 8'hFB;
    localparam int unsigned TIMEBASE_LEN = 5;

    localparam logic [7:0]  SENSOR_CHANNEL_DEF  = 8'd3;
    localparam logic [7:0]  QUAT_REPORT_ID_DEF  = 8'h05;
    localparam int unsigned QUAT_REPORT_LEN_DEF = 14;
    localparam logic [7:0]  GYRO_REPORT_ID_DEF  = 8'h02;
    localparam int unsigned GYRO_REPORT_LEN_DEF = 10;
    localparam logic [23:0] STALE_CYCLES_DEF    = 24'd6_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RPT_ID,
        ST_TBASE,
        ST_BODY,
        ST_SKIP
    } parser_state_t;

    // Value fields start at report byte 4, two bytes each (lsb first).
    function automatic logic [1:0] field_sel(input logic [3:0] idx);
        logic [3:0] off;
        off = idx - 4'd4;
        return off[2:1];
    endfunction

endpackage

// File: rtl/bno085_stale_timer.sv
// Freshness tracker: valid stays high for STALE_CYCLES clocks after each load.
module bno085_stale_timer
    import bno085_pkg::*;
#(
    parameter logic [23:0] STALE_CYCLES = STALE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic valid_o
);

    logic [23:0] cnt_q;
    logic        seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= STALE_CYCLES;
            seen_q <= 1'b1;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 24'd1;
        end
    end

    // A zero timeout disables expiry: valid latches on the first load.
    assign valid_o = (STALE_CYCLES == '0) ? seen_q : (cnt_q != '0);

endmodule

// File: rtl/bno085_report_parser.sv
// Parses SHTP packets into atomically committed quaternion and gyro samples.
module bno085_report_parser
    import bno085_pkg::*;
#(
    parameter logic [7:0]  SENSOR_CHANNEL  = SENSOR_CHANNEL_DEF,
    parameter logic [7:0]  QUAT_REPORT_ID  = QUAT_REPORT_ID_DEF,
    parameter int unsigned QUAT_REPORT_LEN = QUAT_REPORT_LEN_DEF,
    parameter logic [7:0]  GYRO_REPORT_ID  = GYRO_REPORT_ID_DEF,
    parameter int unsigned GYRO_REPORT_LEN = GYRO_REPORT_LEN_DEF,
    parameter logic [23:0] STALE_CYCLES    = STALE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        quat_valid,
    output logic [15:0] quat_w,
    output logic [15:0] quat_x,
    output logic [15:0] quat_y,
    output logic [15:0] quat_z,
    output logic        gyro_valid,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        quat_update,
    output logic        gyro_update,
    output logic        parse_err
);

    localparam logic [3:0] QLEN = 4'(QUAT_REPORT_LEN);
    localparam logic [3:0] GLEN = 4'(GYRO_REPORT_LEN);
    localparam logic [3:0] TLEN = 4'(TIMEBASE_LEN);

    parser_state_t state_q;
    logic [1:0]    hdr_cnt_q;
    logic [7:0]    len_lo_q;
    logic [7:0]    len_hi_q;
    logic [7:0]    chan_q;
    logic [14:0]   rem_q;
    logic [3:0]    idx_q;
    logic [3:0]    rpt_len_q;
    logic          quat_sel_q;

    logic [3:0][15:0] sh_q;
    logic [3:0][15:0] sh_d;

    logic [15:0] quat_w_q, quat_x_q, quat_y_q, quat_z_q;
    logic [15:0] gyro_x_q, gyro_y_q, gyro_z_q;
    logic        quat_update_q, gyro_update_q, parse_err_q;

    logic [14:0] pkt_len;
    logic        hdr_accept;
    logic        accept;
    logic        rpt_last;
    logic        pay_last;
    logic        quat_commit;
    logic        gyro_commit;
    logic        id_is_quat;
    logic        id_is_gyro;
    logic        id_is_tbase;

    assign pkt_len    = {len_hi_q[6:0], len_lo_q};
    assign hdr_accept = !len_hi_q[7] && (pkt_len > 15'(SHTP_HDR_LEN))
                        && (chan_q == SENSOR_CHANNEL);
    assign accept     = byte_valid && !frame_start;
    assign rpt_last   = (idx_q == rpt_len_q - 4'd1);
    assign pay_last   = (rem_q == 15'd1);
    assign id_is_quat  = (byte_data == QUAT_REPORT_ID);
    assign id_is_gyro  = (byte_data == GYRO_REPORT_ID);
    assign id_is_tbase = (byte_data == TIMEBASE_ID);

    // Commit uses the in-flight last byte so outputs appear the following cycle.
    assign quat_commit = accept && (state_q == ST_BODY) && rpt_last && quat_sel_q;
    assign gyro_commit = accept && (state_q == ST_BODY) && rpt_last && !quat_sel_q;

    always_comb begin
        sh_d = sh_q;
        if (accept && (state_q == ST_BODY) && (idx_q >= 4'd4) && (idx_q <= 4'd11)) begin
            if (idx_q[0]) begin
                sh_d[field_sel(idx_q)][15:8] = byte_data;
            end else begin
                sh_d[field_sel(idx_q)][7:0] = byte_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hdr_cnt_q     <= '0;
            len_lo_q      <= '0;
            len_hi_q      <= '0;
            chan_q        <= '0;
            rem_q         <= '0;
            idx_q         <= '0;
            rpt_len_q     <= '0;
            quat_sel_q    <= 1'b0;
            sh_q          <= '0;
            quat_w_q      <= '0;
            quat_x_q      <= '0;
            quat_y_q      <= '0;
            quat_z_q      <= '0;
            gyro_x_q      <= '0;
            gyro_y_q      <= '0;
            gyro_z_q      <= '0;
            quat_update_q <= 1'b0;
            gyro_update_q <= 1'b0;
            parse_err_q   <= 1'b0;
        end else begin
            quat_update_q <= 1'b0;
            gyro_update_q <= 1'b0;
            parse_err_q   <= 1'b0;
            sh_q          <= sh_d;

            if (frame_start) begin
                parse_err_q <= (state_q == ST_BODY);
                state_q     <= ST_HDR;
                hdr_cnt_q   <= byte_valid ? 2'd1 : 2'd0;
                if (byte_valid) begin
                    len_lo_q <= byte_data;
                end
            end else if (byte_valid) begin
                case (state_q)
                    ST_HDR: begin
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        case (hdr_cnt_q)
                            2'd0: len_lo_q <= byte_data;
                            2'd1: len_hi_q <= byte_data;
                            2'd2: chan_q   <= byte_data;
                            default: begin
                                rem_q   <= pkt_len - 15'(SHTP_HDR_LEN);
                                state_q <= hdr_accept ? ST_RPT_ID : ST_IDLE;
                            end
                        endcase
                    end

                    ST_RPT_ID: begin
                        rem_q      <= rem_q - 15'd1;
                        idx_q      <= 4'd1;
                        sh_q       <= '0;
                        quat_sel_q <= id_is_quat;
                        rpt_len_q  <= id_is_tbase ? TLEN : (id_is_quat ? QLEN : GLEN);
                        if (id_is_tbase || id_is_quat || id_is_gyro) begin
                            if (pay_last) begin
                                parse_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                state_q <= id_is_tbase ? ST_TBASE : ST_BODY;
                            end
                        end else begin
                            state_q <= pay_last ? ST_IDLE : ST_SKIP;
                        end
                    end

                    ST_TBASE, ST_BODY: begin
                        rem_q <= rem_q - 15'd1;
                        idx_q <= idx_q + 4'd1;
                        if (rpt_last) begin
                            state_q <= pay_last ? ST_IDLE : ST_RPT_ID;
                        end else if (pay_last) begin
                            parse_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                        if (quat_commit) begin
                            quat_x_q      <= sh_d[0];
                            quat_y_q      <= sh_d[1];
                            quat_z_q      <= sh_d[2];
                            quat_w_q      <= sh_d[3];
                            quat_update_q <= 1'b1;
                        end
                        if (gyro_commit) begin
                            gyro_x_q      <= sh_d[0];
                            gyro_y_q      <= sh_d[1];
                            gyro_z_q      <= sh_d[2];
                            gyro_update_q <= 1'b1;
                        end
                    end

                    ST_SKIP: begin
                        rem_q <= rem_q - 15'd1;
                        if (pay_last) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    bno085_stale_timer #(.STALE_CYCLES(STALE_CYCLES)) u_quat_stale (
        .clk     (clk),
        .rst     (rst),
        .load_i  (quat_commit),
        .valid_o (quat_valid)
    );

    bno085_stale_timer #(.STALE_CYCLES(STALE_CYCLES)) u_gyro_stale (
        .clk     (clk),
        .rst     (rst),
        .load_i  (gyro_commit),
        .valid_o (gyro_valid)
    );

    assign quat_w      = quat_w_q;
    assign quat_x      = quat_x_q;
    assign quat_y      = quat_y_q;
    assign quat_z      = quat_z_q;
    assign gyro_x      = gyro_x_q;
    assign gyro_y      = gyro_y_q;
    assign gyro_z      = gyro_z_q;
    assign quat_update = quat_update_q;
    assign gyro_update = gyro_update_q;
    assign parse_err   = parse_err_q;

endmodule
